// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the MIPS32 execute stage: aluop/alusel codes,
// double-width bus type, divider state encoding and start/stop levels.
package ex_muldiv_pkg;

  // Logic ops
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  // Shift ops
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  // Move ops
  localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
  localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  // Multiply / divide ops
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  // Result classes
  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

  // {HI,LO}-wide bus
  typedef logic [63:0] dreg_t;

  // Divider states
  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_BUSY   = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_e;

  localparam logic DIV_STOP  = 1'b0;
  localparam logic DIV_START = 1'b1;

  // Two's-complement negation of a 32-bit word
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed fix-up on
// the final step. result_o = {remainder, quotient}, valid while ready_o=1.
module div_iter
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output dreg_t       result_o,
  output logic        ready_o
);

  localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

  div_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        ready_q;
  dreg_t       result_q;

  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic        fits;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits.
  always_comb begin
    fits  = ({rem_q, quo_q[31]} >= {1'b0, dvs_q});
    rem_d = {rem_q[30:0], quo_q[31]};
    quo_d = {quo_q[30:0], 1'b0};
    if (fits) begin
      rem_d = {rem_q[30:0], quo_q[31]} - dvs_q;
      quo_d = {quo_q[30:0], 1'b1};
    end
    quo_fix = neg_quo_q ? neg32(quo_d) : quo_d;
    rem_fix = neg_rem_q ? neg32(rem_d) : rem_d;
  end

  // Divider FSM; annul wins over every state including DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else if (annul_i) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          ready_q <= 1'b0;
          cnt_q   <= '0;
          if (start_i) begin
            if (opdata2_i == '0) begin
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= DIV_BYZERO;
            end else begin
              rem_q     <= '0;
              quo_q     <= (signed_i && opdata1_i[31]) ? neg32(opdata1_i) : opdata1_i;
              dvs_q     <= (signed_i && opdata2_i[31]) ? neg32(opdata2_i) : opdata2_i;
              neg_quo_q <= signed_i && (opdata1_i[31] ^ opdata2_i[31]);
              neg_rem_q <= signed_i && opdata1_i[31];
              state_q   <= DIV_BUSY;
            end
          end
        end
        DIV_BYZERO: begin
          result_q <= '0;
          ready_q  <= 1'b1;
          state_q  <= DIV_DONE;
        end
        DIV_BUSY: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (cnt_q == LAST_STEP) begin
            result_q <= {rem_fix, quo_fix};
            ready_q  <= 1'b1;
            state_q  <= DIV_DONE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DIV_DONE: begin
          ready_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: rtl/ex_muldiv.sv
// MIPS32 execute stage: logic/shift/move ALU, HI/LO pair, iterative divider
// with stall request. Optional single-cycle MULT/MULTU under `EX_MULT_EN.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [31:0] wdata_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] wdata_q;
  logic [4:0]  wd_q;
  logic        wreg_q;

  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [31:0] move_res;
  logic [31:0] alu_res;

  logic        is_div;
  logic        div_start;
  logic        div_ready;
  dreg_t       div_result;
  logic        stall;

`ifdef EX_MULT_EN
  logic        is_mult;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  dreg_t       mult_prod;

  // Low 64 bits of the product of the extended operands are exact for both
  // signed and unsigned multiply.
  always_comb begin
    is_mult   = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
    mul_a     = (aluop_i == EXE_MULT_OP) ? {{32{reg1_i[31]}}, reg1_i} : {32'd0, reg1_i};
    mul_b     = (aluop_i == EXE_MULT_OP) ? {{32{reg2_i[31]}}, reg2_i} : {32'd0, reg2_i};
    mult_prod = mul_a * mul_b;
  end
`endif

  // Per-class results, selected by alusel.
  always_comb begin
    logic_res = '0;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = '0;
    endcase

    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = $signed(reg2_i) >>> reg1_i[4:0];
      default:    shift_res = '0;
    endcase

    move_res = '0;
    case (aluop_i)
      EXE_MOVZ_OP, EXE_MOVN_OP: move_res = reg1_i;
      EXE_MFHI_OP:              move_res = hi_q;
      EXE_MFLO_OP:              move_res = lo_q;
      default:                  move_res = '0;
    endcase

    case (alusel_i)
      EXE_RES_LOGIC: alu_res = logic_res;
      EXE_RES_SHIFT: alu_res = shift_res;
      EXE_RES_MOVE:  alu_res = move_res;
      default:       alu_res = '0;
    endcase
  end

  // Divide request and pipeline stall; stall drops in DONE and under flush.
  always_comb begin
    is_div    = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    div_start = is_div ? DIV_START : DIV_STOP;
    stall     = rst && is_div && !div_ready && !flush_i;
  end

  div_iter #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .signed_i  (aluop_i == EXE_DIV_OP),
    .opdata1_i (reg1_i),
    .opdata2_i (reg2_i),
    .annul_i   (flush_i),
    .result_o  (div_result),
    .ready_o   (div_ready)
  );

  // HI/LO update: divider completion first, then multiply, then MTHI/MTLO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (!flush_i) begin
      if (div_ready) begin
        hi_q <= div_result[63:32];
        lo_q <= div_result[31:0];
      end
`ifdef EX_MULT_EN
      else if (is_mult) begin
        hi_q <= mult_prod[63:32];
        lo_q <= mult_prod[31:0];
      end
`endif
      else if (aluop_i == EXE_MTHI_OP) begin
        hi_q <= reg1_i;
      end else if (aluop_i == EXE_MTLO_OP) begin
        lo_q <= reg1_i;
      end
    end
  end

  // Result bundle to the memory stage; flush and stall both emit a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdata_q <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
    end else if (flush_i) begin
      wdata_q <= '0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
    end else if (stall) begin
      wdata_q <= '0;
      wd_q    <= wd_i;
      wreg_q  <= 1'b0;
    end else begin
      wdata_q <= alu_res;
      wd_q    <= wd_i;
      wreg_q  <= wreg_i;
    end
  end

  assign wdata_o    = wdata_q;
  assign wd_o       = wd_q;
  assign wreg_o     = wreg_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
  assign stallreq_o = stall;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: scoreboard of single-cycle results plus
// divide timing/result checks, flush and asynchronous reset mid-divide.
`timescale 1ns/1ps
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  aluop = EXE_NOP_OP;
  logic [2:0]  alusel = EXE_RES_NOP;
  logic [31:0] reg1 = '0;
  logic [31:0] reg2 = '0;
  logic [4:0]  wd = '0;
  logic        wreg = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
  } exp_t;

  exp_t sb[$];

  ex_muldiv #(.DIV_CYCLES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .alusel_i   (alusel),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .wd_i       (wd),
    .wreg_i     (wreg),
    .flush_i    (flush),
    .wdata_o    (wdata_o),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] d, input logic we);
    aluop  = op;
    alusel = sel;
    reg1   = r1;
    reg2   = r2;
    wd     = d;
    wreg   = we;
  endtask

  // Drive a single-cycle op, queue its expectation, compare after the edge.
  task automatic issue(input string tag, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] d,
                       input logic we, input logic [31:0] exp_wdata);
    exp_t e;
    drive(op, sel, r1, r2, d, we);
    sb.push_back(exp_t'{wdata: exp_wdata, wd: d, wreg: we});
    @(posedge clk); #1;
    e = sb.pop_front();
    check_eq({tag, ".wdata"}, {32'd0, wdata_o}, {32'd0, e.wdata});
    check_eq({tag, ".wd"},    {59'd0, wd_o},    {59'd0, e.wd});
    check_eq({tag, ".wreg"},  {63'd0, wreg_o},  {63'd0, e.wreg});
  endtask

  // Run a divide to completion: count stall cycles, then check HI/LO.
  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] r1,
                         input logic [31:0] r2, input int exp_stall,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int cnt;
    cnt = 0;
    drive(op, EXE_RES_NOP, r1, r2, 5'd0, 1'b0);
    #1;
    while (stallreq_o === 1'b1 && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
    check_eq({tag, ".stall_cycles"}, 64'(cnt), 64'(exp_stall));
    check_eq({tag, ".bubble"}, {63'd0, wreg_o}, 64'd0);
    @(posedge clk); #1;
    drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0, 5'd0, 1'b0);
    #1;
    check_eq({tag, ".lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
    check_eq({tag, ".hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
    check_eq({tag, ".stall_after"}, {63'd0, stallreq_o}, 64'd0);
  endtask

  function automatic logic [31:0] model_op(input int k, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    int unsigned s;
    s = int'(a[4:0]);
    r = '0;
    case (k)
      0: r = a & b;
      1: r = a | b;
      2: r = a ^ b;
      3: r = ~(a | b);
      4: for (int i = 0; i < 32; i++) r[i] = (i >= int'(s)) ? b[i - int'(s)] : 1'b0;
      5: for (int i = 0; i < 32; i++) r[i] = (i + int'(s) < 32) ? b[i + int'(s)] : 1'b0;
      default: for (int i = 0; i < 32; i++) r[i] = (i + int'(s) < 32) ? b[i + int'(s)] : b[31];
    endcase
    return r;
  endfunction

  initial begin
    logic [7:0]  ops[7];
    logic [2:0]  sels[7];
    logic [31:0] a, b, lo_before, hi_before;
    int          k;

    ops[0] = EXE_AND_OP; ops[1] = EXE_OR_OP;  ops[2] = EXE_XOR_OP; ops[3] = EXE_NOR_OP;
    ops[4] = EXE_SLL_OP; ops[5] = EXE_SRL_OP; ops[6] = EXE_SRA_OP;
    for (int i = 0; i < 7; i++) sels[i] = (i < 4) ? EXE_RES_LOGIC : EXE_RES_SHIFT;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.wdata", {32'd0, wdata_o}, 64'd0);
    check_eq("rst.wreg",  {63'd0, wreg_o}, 64'd0);
    check_eq("rst.hilo",  {hi_o, lo_o}, 64'd0);
    check_eq("rst.stall", {63'd0, stallreq_o}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed single-cycle ops
    issue("or",   EXE_OR_OP,  EXE_RES_LOGIC, 32'h0000F0F0, 32'h00FF0000, 5'd5, 1'b1, 32'h00FFF0F0);
    issue("sra",  EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h80000010, 5'd6, 1'b1, 32'hF8000001);
    issue("srl",  EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h80000010, 5'd6, 1'b1, 32'h08000001);
    issue("unk",  8'hFF,      EXE_RES_LOGIC, 32'h1234, 32'h5678, 5'd7, 1'b1, 32'd0);
    issue("movz", EXE_MOVZ_OP, EXE_RES_MOVE, 32'hDEADBEEF, 32'd0, 5'd8, 1'b1, 32'hDEADBEEF);

    // Randomised logic/shift ops against the bench model
    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, 6);
      a = $urandom;
      b = $urandom;
      if (n == 0) b = 32'h8000_0001;
      issue("rand", ops[k], sels[k], a, b, 5'($urandom_range(1, 31)), 1'b1, model_op(k, a, b));
    end

    // MT then MF in the following cycle
    lo_before = lo_o;
    issue("mthi", EXE_MTHI_OP, EXE_RES_NOP, 32'h12345678, 32'd0, 5'd0, 1'b0, 32'd0);
    issue("mfhi", EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd3, 1'b1, 32'h12345678);
    check_eq("mthi.hi", {32'd0, hi_o}, 64'h12345678);
    check_eq("mthi.lo", {32'd0, lo_o}, {32'd0, lo_before});
    issue("mtlo", EXE_MTLO_OP, EXE_RES_NOP, 32'hCAFEBABE, 32'd0, 5'd0, 1'b0, 32'd0);
    issue("mflo", EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0, 5'd4, 1'b1, 32'hCAFEBABE);
    check_eq("mtlo.hi", {32'd0, hi_o}, 64'h12345678);

    // Multiply
`ifdef EX_MULT_EN
    issue("mult", EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0, 32'd0);
    check_eq("mult.hilo", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFA);
    issue("multu", EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0, 32'd0);
    check_eq("multu.hilo", {hi_o, lo_o}, 64'h00000002_FFFFFFFA);
`else
    issue("mult", EXE_MULT_OP, EXE_RES_NOP, 32'hFFFFFFFE, 32'd3, 5'd0, 1'b0, 32'd0);
    check_eq("mult.hilo", {hi_o, lo_o}, 64'h12345678_CAFEBABE);
`endif

    // Divides
    run_div("div_neg", EXE_DIV_OP, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div("divu",    EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_div("div0",    EXE_DIVU_OP, 32'd5, 32'd0, 2, 32'd0, 32'd0);
    run_div("divu2",   EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);

    // Flush during BUSY
    hi_before = hi_o;
    lo_before = lo_o;
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd0, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    check_eq("flush.pre_stall", {63'd0, stallreq_o}, 64'd1);
    flush = 1'b1;
    #1;
    check_eq("flush.stall", {63'd0, stallreq_o}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0, 5'd0, 1'b0);
    check_eq("flush.wreg",  {63'd0, wreg_o}, 64'd0);
    check_eq("flush.wdata", {32'd0, wdata_o}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check_eq("flush.hilo", {hi_o, lo_o}, {hi_before, lo_before});
    run_div("div_ovf", EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000, 32'd0);

    // Reset mid-divide
    drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd9, 1'b0);
    repeat (6) @(posedge clk);
    #2;
    check_eq("rstmid.wd_pre", {59'd0, wd_o}, 64'd9);
    rst = 1'b0;
    #1;
    check_eq("rstmid.wdata", {32'd0, wdata_o}, 64'd0);
    check_eq("rstmid.wd",    {59'd0, wd_o}, 64'd0);
    check_eq("rstmid.wreg",  {63'd0, wreg_o}, 64'd0);
    check_eq("rstmid.hilo",  {hi_o, lo_o}, 64'd0);
    check_eq("rstmid.stall", {63'd0, stallreq_o}, 64'd0);
    drive(EXE_NOP_OP, EXE_RES_NOP, '0, '0, 5'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_div("div_after_rst", EXE_DIV_OP, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
